dcache_ctrl: RTL

// - MEM-stage responder for the EX/MEM register's memory-request outputs (MemRead, MemWrite, ALUOut address, RT write data).
// - Direct-mapped, one-word-per-line data cache. Write-through, no-write-allocate.
// - Fronted by a multi-cycle backing memory using a req/ack handshake.
// - Generates the stall_o that freezes the pipeline registers (including EX/MEM) while a memory transaction is outstanding.

---
 rtl/dcache_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: MEM-stage data cache controller.
// Direct-mapped, one word per line, write-through, no-write-allocate,
// backed by a multi-cycle memory with a req/ack handshake. stall_o freezes
// the pipeline while a backing-memory transaction is outstanding.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
    parameter int INDEX_BITS = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RMISS = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [31:0]           data_q [LINES];
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rd_done_q, rd_done_d;

    logic [INDEX_BITS-1:0] idx_s;
    logic [TAG_BITS-1:0]   tag_s;
    logic                  hit_s;
    logic [INDEX_BITS-1:0] fill_idx_s;
    logic [TAG_BITS-1:0]   fill_tag_s;
    logic                  fill_s;
    logic                  wr_upd_s;
    logic                  stall_s;
    logic [31:0]           rdata_s;
    logic                  unused_s;

    // Byte offset is irrelevant for word accesses.
    assign unused_s   = ^addr_i[1:0];
    assign idx_s      = addr_i[INDEX_BITS+1:2];
    assign tag_s      = addr_i[31:INDEX_BITS+2];
    assign hit_s      = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
    // Fills use the latched request address so the line written always matches the request issued.
    assign fill_idx_s = mem_addr_q[INDEX_BITS+1:2];
    assign fill_tag_s = mem_addr_q[31:INDEX_BITS+2];

    // Next-state, memory-request and pipeline-facing output decode.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        rd_done_d   = rd_done_q;
        fill_s      = 1'b0;
        wr_upd_s    = 1'b0;
        stall_s     = 1'b0;
        rdata_s     = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (MemWrite_i) begin
                    // Read+write together is treated as a plain write.
                    stall_s     = 1'b1;
                    wr_upd_s    = hit_s;
                    state_d     = ST_WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {addr_i[31:2], 2'b00};
                    mem_wdata_d = wdata_i;
                end else if (MemRead_i) begin
                    if (hit_s) begin
                        rdata_s = data_q[idx_s];
                    end else begin
                        stall_s    = 1'b1;
                        state_d    = ST_RMISS;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {addr_i[31:2], 2'b00};
                    end
                end else begin
                    stall_s = 1'b0;
                end
            end
            ST_RMISS: begin
                stall_s = 1'b1;
                if (mem_ack_i) begin
                    fill_s    = 1'b1;
                    rdata_d   = mem_rdata_i;
                    mem_req_d = 1'b0;
                    rd_done_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_RMISS;
                end
            end
            ST_WRITE: begin
                stall_s = 1'b1;
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    rd_done_d = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                if (rd_done_q) begin
                    rdata_s = rdata_q;
                end else begin
                    rdata_s = 32'h0000_0000;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign stall_o     = stall_s;
    assign rdata_o     = rdata_s;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    // Control state, request registers and valid bits with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
            rd_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            rd_done_q   <= rd_done_d;
            if (fill_s) begin
                valid_q[fill_idx_s] <= 1'b1;
            end else begin
                valid_q <= valid_q;
            end
        end
    end

    // Tag/data storage; contents are meaningless until the valid bit is set, so no reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // A reset abandons any fill or store in flight.
        end else if (fill_s) begin
            tag_q[fill_idx_s]  <= fill_tag_s;
            data_q[fill_idx_s] <= mem_rdata_i;
        end else if (wr_upd_s) begin
            data_q[idx_s] <= wdata_i;
        end else begin
            // No storage update this cycle.
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        cnt_hit_s;
    logic        cnt_miss_s;

    assign cnt_hit_s  = (state_q == ST_IDLE) && MemRead_i && !MemWrite_i && hit_s;
    assign cnt_miss_s = (state_q == ST_IDLE) && (state_d == ST_RMISS);

    // Saturating read hit/miss counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= 32'h0000_0000;
            miss_cnt_q <= 32'h0000_0000;
        end else begin
            if (cnt_hit_s && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                hit_cnt_q <= hit_cnt_q;
            end
            if (cnt_miss_s && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
